gpr_wb_ctrl: RTL and testbench
==============================

Name: gpr_wb_ctrl

Overview:
Writeback controller for the single GPR write port. It arbitrates between the execute stage (ALU result or PC link value) and returning load data. It tracks registers with outstanding loads in a scoreboard and drives the select, operands, write enable and address consumed by gpr_write_mux and the register file. One-entry skid buffer absorbs execute results displaced by load returns.

Parameters:
DATA_W, 32, width of every data operand
ADDR_W, 5, GPR address width (32 registers)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  execute result offered
ex_ready  out  1  execute result accepted when ex_valid&ex_ready
ex_src  in  1  0 = ALU result, 1 = PC link value
ex_waddr  in  ADDR_W  destination register
ex_data  in  DATA_W  result value
li_valid  in  1  load issue (reserves destination)
li_ready  out  1  load issue accepted when li_valid&li_ready
li_waddr  in  ADDR_W  load destination
ld_valid  in  1  load data return; always accepted, no backpressure
ld_waddr  in  ADDR_W  load destination
ld_data  in  DATA_W  loaded value
gpr_we  out  1  register-file write enable
gpr_waddr  out  ADDR_W  write address
gpr_sel  out  2  mux select, `GPR_WRITE_ALU / `GPR_WRITE_MEM / `GPR_WRITE_PC
gpr_alu  out  DATA_W  mux ALU operand
gpr_mem  out  DATA_W  mux memory operand
gpr_pc  out  DATA_W  mux PC operand
busy  out  2**ADDR_W  scoreboard, bit r = load outstanding to r
wb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low at edge): gpr_we=0, gpr_waddr=0, gpr_sel=`GPR_WRITE_ALU, gpr_alu/mem/pc=0, busy=0, skid empty, wb_err=0. Applies mid-operation and discards skid contents and pending scoreboard bits.
- Readiness, combinational:
  - ex_ready = !skid_full && !(busy[ex_waddr] && ex_waddr!=0). This is the WAW stall behind an outstanding load.
  - li_ready = li_waddr==0 || !busy[li_waddr] || (ld_valid && ld_waddr==li_waddr).
- Write priority per cycle: ld_valid > skid entry > newly accepted execute.
  - Load wins: gpr_sel=`GPR_WRITE_MEM, gpr_mem=ld_data.
  - Execute/skid: gpr_sel=`GPR_WRITE_PC if src=1, else `GPR_WRITE_ALU. gpr_pc or gpr_alu takes the data.
  - Non-selected operand registers hold their value.
- Latency: registered outputs, exactly 1 cycle from winning input to gpr_we/gpr_waddr/gpr_sel/operand.
- Skid:
  - Accepted execute and ld_valid in the same cycle: execute goes into the skid (skid_full next cycle).
  - Skid full and no ld_valid: skid drains. ex_ready is low that cycle, so ordering is preserved.
  - Back-to-back load returns keep the skid full indefinitely.
- Idle cycle (no winner): gpr_we=0, other outputs hold.
- Register 0: write slot consumed, gpr_we=0, gpr_waddr=0. li_waddr=0 never sets busy; ld_waddr=0 is not an error.
- Scoreboard:
  - Accepted li sets busy[li_waddr]. ld_valid clears busy[ld_waddr].
  - Same register set and cleared in one cycle: set wins (bit stays 1).
- wb_err set, sticky until reset, when:
  - ld_valid with ld_waddr!=0 and busy[ld_waddr]==0; the write still occurs.
  - ex_valid drops or ex_waddr/ex_src/ex_data changes while ex_valid&&!ex_ready.

Optional Feature:
GPR_WB_STATS_EN
- Defined: adds outputs stall_cnt (32) and skid_cnt (32), both reset to 0 and saturating at 0xFFFFFFFF.
  - stall_cnt increments each cycle ex_valid&&!ex_ready.
  - skid_cnt increments each time an execute result enters the skid.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then execute ALU write: ex_valid, src=0, waddr=5, data=0x00c0ffee -> next cycle gpr_we=1, waddr=5, sel=`GPR_WRITE_ALU, gpr_alu=0x00c0ffee.
- Collision: ex (src=1, waddr=31, data=0xdeadbeef) and ld_valid (waddr=8, data=0xbaadc0de) same cycle. Required:
  - Cycle+1: MEM write to 8.
  - Cycle+1: ex_ready=0.
  - Cycle+2: PC write to 31, value 0xdeadbeef.
- Scoreboard stall: li waddr=9 accepted -> busy[9]=1; ex waddr=9 held, ex_ready=0 until ld_valid waddr=9. ld write lands first, ex write to 9 the following cycle.
- Same-cycle li and ld to register 12 while busy[12]=1 -> li_ready=1, busy[12] remains 1, no wb_err.
- Register 0: ex waddr=0 data=0x12345678 -> gpr_we=0. Stray ld_valid waddr=3 with busy[3]=0 -> write occurs, wb_err=1 until rst_n low.
- Reset mid-operation: skid full, busy[4]=1, rst_n low one cycle -> all outputs at reset values, ex_ready=1, busy=0.

Source files
------------

// File: rtl/gpr_wb_ctrl_if.sv
// Writeback bundle between the pipeline (master) and gpr_wb_ctrl (slave):
// execute offer, load issue, load return and the GPR write-port drive.
interface gpr_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_src;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_data;
  logic              li_valid;
  logic              li_ready;
  logic [ADDR_W-1:0] li_waddr;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0] ld_data;
  logic              gpr_we;
  logic [ADDR_W-1:0] gpr_waddr;
  logic [1:0]        gpr_sel;
  logic [DATA_W-1:0] gpr_alu;
  logic [DATA_W-1:0] gpr_mem;
  logic [DATA_W-1:0] gpr_pc;

  modport master (
    output ex_valid, ex_src, ex_waddr, ex_data,
    output li_valid, li_waddr,
    output ld_valid, ld_waddr, ld_data,
    input  ex_ready, li_ready,
    input  gpr_we, gpr_waddr, gpr_sel, gpr_alu, gpr_mem, gpr_pc
  );

  modport slave (
    input  ex_valid, ex_src, ex_waddr, ex_data,
    input  li_valid, li_waddr,
    input  ld_valid, ld_waddr, ld_data,
    output ex_ready, li_ready,
    output gpr_we, gpr_waddr, gpr_sel, gpr_alu, gpr_mem, gpr_pc
  );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: load/skid/execute arbitration, load scoreboard, skid buffer.
// Optional GPR_WB_STATS_EN adds saturating stall_cnt / skid_cnt outputs.
`ifndef GPR_WRITE_ALU
`define GPR_WRITE_ALU 2'd0
`endif
`ifndef GPR_WRITE_MEM
`define GPR_WRITE_MEM 2'd1
`endif
`ifndef GPR_WRITE_PC
`define GPR_WRITE_PC 2'd2
`endif

module gpr_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gpr_wb_ctrl_if.slave         bus,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 wb_err
`ifdef GPR_WB_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          skid_cnt
`endif
);
  localparam int NREG = 2**ADDR_W;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [NREG-1:0]   busy_q, busy_nxt;
  logic              err_q, err_nxt;

  logic              skid_full_p0;
  logic              skid_src_p0;
  logic [ADDR_W-1:0] skid_waddr_p0;
  logic [DATA_W-1:0] skid_data_p0;

  logic              stall_p0;
  logic              hold_src_p0;
  logic [ADDR_W-1:0] hold_waddr_p0;
  logic [DATA_W-1:0] hold_data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [1:0]        sel_p1;
  logic [DATA_W-1:0] alu_p1, mem_p1, pc_p1;

  logic              ex_ready, li_ready, ex_acc, li_acc;
  logic              win_vld, skid_load, skid_drain;
  logic [1:0]        win_sel;
  logic [ADDR_W-1:0] win_waddr;
  logic [DATA_W-1:0] win_data;

  // Stage p0: readiness, arbitration, scoreboard and error next-state
  assign ex_ready = !skid_full_p0 && !(busy_q[bus.ex_waddr] && bus.ex_waddr != '0);
  assign li_ready = (bus.li_waddr == '0) || !busy_q[bus.li_waddr] ||
                    (bus.ld_valid && bus.ld_waddr == bus.li_waddr);
  assign ex_acc   = bus.ex_valid && ex_ready;
  assign li_acc   = bus.li_valid && li_ready;

  always_comb begin
    win_vld    = 1'b0;
    win_sel    = `GPR_WRITE_ALU;
    win_waddr  = '0;
    win_data   = '0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (bus.ld_valid) begin
      win_vld   = 1'b1;
      win_sel   = `GPR_WRITE_MEM;
      win_waddr = bus.ld_waddr;
      win_data  = bus.ld_data;
      skid_load = ex_acc;
    end else if (skid_full_p0) begin
      win_vld    = 1'b1;
      win_sel    = skid_src_p0 ? `GPR_WRITE_PC : `GPR_WRITE_ALU;
      win_waddr  = skid_waddr_p0;
      win_data   = skid_data_p0;
      skid_drain = 1'b1;
    end else if (ex_acc) begin
      win_vld   = 1'b1;
      win_sel   = bus.ex_src ? `GPR_WRITE_PC : `GPR_WRITE_ALU;
      win_waddr = bus.ex_waddr;
      win_data  = bus.ex_data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.ld_valid) busy_nxt[bus.ld_waddr] = 1'b0;
    if (li_acc && bus.li_waddr != '0) busy_nxt[bus.li_waddr] = 1'b1;
  end

  always_comb begin
    err_nxt = err_q;
    if (bus.ld_valid && bus.ld_waddr != '0 && !busy_q[bus.ld_waddr]) err_nxt = 1'b1;
    if (stall_p0 && (!bus.ex_valid || bus.ex_src != hold_src_p0 ||
                     bus.ex_waddr != hold_waddr_p0 || bus.ex_data != hold_data_p0))
      err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      err_q         <= 1'b0;
      skid_full_p0  <= 1'b0;
      skid_src_p0   <= 1'b0;
      skid_waddr_p0 <= '0;
      skid_data_p0  <= '0;
      stall_p0      <= 1'b0;
      hold_src_p0   <= 1'b0;
      hold_waddr_p0 <= '0;
      hold_data_p0  <= '0;
      vld_p1        <= 1'b0;
      waddr_p1      <= '0;
      sel_p1        <= `GPR_WRITE_ALU;
      alu_p1        <= '0;
      mem_p1        <= '0;
      pc_p1         <= '0;
    end else begin
      busy_q        <= busy_nxt;
      err_q         <= err_nxt;
      stall_p0      <= bus.ex_valid && !ex_ready;
      hold_src_p0   <= bus.ex_src;
      hold_waddr_p0 <= bus.ex_waddr;
      hold_data_p0  <= bus.ex_data;
      if (skid_load) begin
        skid_full_p0  <= 1'b1;
        skid_src_p0   <= bus.ex_src;
        skid_waddr_p0 <= bus.ex_waddr;
        skid_data_p0  <= bus.ex_data;
      end else if (skid_drain) begin
        skid_full_p0  <= 1'b0;
      end
      // Stage p1: registered write port; r0 consumes the slot without a write
      vld_p1 <= win_vld && win_waddr != '0;
      if (win_vld) begin
        waddr_p1 <= win_waddr;
        sel_p1   <= win_sel;
        case (win_sel)
          `GPR_WRITE_MEM: mem_p1 <= win_data;
          `GPR_WRITE_PC:  pc_p1  <= win_data;
          default:        alu_p1 <= win_data;
        endcase
      end
    end
  end

`ifdef GPR_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      skid_cnt  <= '0;
    end else begin
      if (bus.ex_valid && !ex_ready) stall_cnt <= sat_inc(stall_cnt);
      if (skid_load)                 skid_cnt  <= sat_inc(skid_cnt);
    end
  end
`endif

  assign bus.ex_ready  = ex_ready;
  assign bus.li_ready  = li_ready;
  assign bus.gpr_we    = vld_p1;
  assign bus.gpr_waddr = waddr_p1;
  assign bus.gpr_sel   = sel_p1;
  assign bus.gpr_alu   = alu_p1;
  assign bus.gpr_mem   = mem_p1;
  assign bus.gpr_pc    = pc_p1;
  assign busy          = busy_q;
  assign wb_err        = err_q;
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl: ALU/PC/MEM writes, collision skid,
// WAW stall, scoreboard set/clear, register 0, stray load, protocol error, reset.
`ifndef GPR_WRITE_ALU
`define GPR_WRITE_ALU 2'd0
`endif
`ifndef GPR_WRITE_MEM
`define GPR_WRITE_MEM 2'd1
`endif
`ifndef GPR_WRITE_PC
`define GPR_WRITE_PC 2'd2
`endif

module tb_gpr_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] busy;
  logic        wb_err;
`ifdef GPR_WB_STATS_EN
  logic [31:0] stall_cnt, skid_cnt;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  gpr_wb_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  gpr_wb_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .wb_err (wb_err)
`ifdef GPR_WB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .skid_cnt  (skid_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 1'b0; bus.ex_src = 1'b0; bus.ex_waddr = '0; bus.ex_data = '0;
    bus.li_valid = 1'b0; bus.li_waddr = '0;
    bus.ld_valid = 1'b0; bus.ld_waddr = '0; bus.ld_data = '0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    bus.li_valid = 1'b1; bus.li_waddr = r;
    #1 check("li_ready_issue", bus.li_ready, 1);
    step();
    bus.li_valid = 1'b0;
    check("busy_set", busy[r], 1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_we", bus.gpr_we, 0);
    check("rst_waddr", bus.gpr_waddr, 0);
    check("rst_sel", bus.gpr_sel, `GPR_WRITE_ALU);
    check("rst_alu", bus.gpr_alu, 0);
    check("rst_busy", busy, 0);
    check("rst_err", wb_err, 0);
    check("rst_ex_ready", bus.ex_ready, 1);

    // ALU write to r5
    bus.ex_valid = 1'b1; bus.ex_src = 1'b0; bus.ex_waddr = 5'd5; bus.ex_data = 32'h00c0ffee;
    #1 check("alu_ready", bus.ex_ready, 1);
    step();
    bus.ex_valid = 1'b0;
    check("alu_we", bus.gpr_we, 1);
    check("alu_waddr", bus.gpr_waddr, 5);
    check("alu_sel", bus.gpr_sel, `GPR_WRITE_ALU);
    check("alu_data", bus.gpr_alu, 32'h00c0ffee);
    step();
    check("idle_we", bus.gpr_we, 0);
    check("idle_alu_hold", bus.gpr_alu, 32'h00c0ffee);

    // Collision: PC result to r31 against load return to r8
    issue_load(5'd8);
    bus.ex_valid = 1'b1; bus.ex_src = 1'b1; bus.ex_waddr = 5'd31; bus.ex_data = 32'hdeadbeef;
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd8; bus.ld_data = 32'hbaadc0de;
    step();
    bus.ex_valid = 1'b0; bus.ld_valid = 1'b0;
    #1;
    check("col_ld_we", bus.gpr_we, 1);
    check("col_ld_waddr", bus.gpr_waddr, 8);
    check("col_ld_sel", bus.gpr_sel, `GPR_WRITE_MEM);
    check("col_ld_mem", bus.gpr_mem, 32'hbaadc0de);
    check("col_ex_ready", bus.ex_ready, 0);
    check("col_busy8", busy[8], 0);
    step();
    check("col_pc_we", bus.gpr_we, 1);
    check("col_pc_waddr", bus.gpr_waddr, 31);
    check("col_pc_sel", bus.gpr_sel, `GPR_WRITE_PC);
    check("col_pc_data", bus.gpr_pc, 32'hdeadbeef);
    check("col_alu_hold", bus.gpr_alu, 32'h00c0ffee);
    check("col_ready_back", bus.ex_ready, 1);
    check("col_err", wb_err, 0);

    // WAW stall behind outstanding load to r9
    issue_load(5'd9);
    bus.ex_valid = 1'b1; bus.ex_src = 1'b0; bus.ex_waddr = 5'd9; bus.ex_data = 32'h11111111;
    #1 check("waw_stall", bus.ex_ready, 0);
    step();
    check("waw_idle_we", bus.gpr_we, 0);
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd9; bus.ld_data = 32'h99999999;
    #1 check("waw_stall_ld", bus.ex_ready, 0);
    step();
    bus.ld_valid = 1'b0;
    #1;
    check("waw_ld_we", bus.gpr_we, 1);
    check("waw_ld_waddr", bus.gpr_waddr, 9);
    check("waw_ld_sel", bus.gpr_sel, `GPR_WRITE_MEM);
    check("waw_ld_mem", bus.gpr_mem, 32'h99999999);
    check("waw_release", bus.ex_ready, 1);
    step();
    bus.ex_valid = 1'b0;
    check("waw_ex_we", bus.gpr_we, 1);
    check("waw_ex_waddr", bus.gpr_waddr, 9);
    check("waw_ex_sel", bus.gpr_sel, `GPR_WRITE_ALU);
    check("waw_ex_alu", bus.gpr_alu, 32'h11111111);
    check("waw_err", wb_err, 0);

    // Same-cycle reissue and return on r12
    issue_load(5'd12);
    bus.li_valid = 1'b1; bus.li_waddr = 5'd12;
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd12; bus.ld_data = 32'h0000cccc;
    #1 check("r12_li_ready", bus.li_ready, 1);
    step();
    bus.li_valid = 1'b0; bus.ld_valid = 1'b0;
    check("r12_busy_kept", busy[12], 1);
    check("r12_err", wb_err, 0);
    check("r12_mem", bus.gpr_mem, 32'h0000cccc);
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd12; bus.ld_data = 32'h0;
    step();
    bus.ld_valid = 1'b0;
    check("r12_cleared", busy, 0);

    // Register 0 and stray load
    bus.ex_valid = 1'b1; bus.ex_src = 1'b0; bus.ex_waddr = 5'd0; bus.ex_data = 32'h12345678;
    step();
    bus.ex_valid = 1'b0;
    check("r0_we", bus.gpr_we, 0);
    check("r0_waddr", bus.gpr_waddr, 0);
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd3; bus.ld_data = 32'h33333333;
    step();
    bus.ld_valid = 1'b0;
    check("stray_we", bus.gpr_we, 1);
    check("stray_waddr", bus.gpr_waddr, 3);
    check("stray_err", wb_err, 1);
    step();
    check("stray_err_sticky", wb_err, 1);

    // Reset mid-operation with skid full and r4 busy
    issue_load(5'd4);
    issue_load(5'd6);
    bus.ex_valid = 1'b1; bus.ex_src = 1'b0; bus.ex_waddr = 5'd7; bus.ex_data = 32'h77777777;
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd6; bus.ld_data = 32'h66666666;
    step();
    idle_inputs();
    bus.ex_waddr = 5'd7;
    #1 check("pre_rst_skid_full", bus.ex_ready, 0);
    check("pre_rst_busy4", busy[4], 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mrst_we", bus.gpr_we, 0);
    check("mrst_waddr", bus.gpr_waddr, 0);
    check("mrst_sel", bus.gpr_sel, `GPR_WRITE_ALU);
    check("mrst_ops", {bus.gpr_alu | bus.gpr_mem | bus.gpr_pc}, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", wb_err, 0);
    check("mrst_ex_ready", bus.ex_ready, 1);
    step();
    check("mrst_skid_dropped", bus.gpr_we, 0);

    // Protocol violation: data changes while stalled
    issue_load(5'd10);
    bus.ex_valid = 1'b1; bus.ex_src = 1'b0; bus.ex_waddr = 5'd10; bus.ex_data = 32'haaaa0000;
    step();
    check("proto_no_err_yet", wb_err, 0);
    bus.ex_data = 32'hbbbb0000;
    step();
    check("proto_err", wb_err, 1);
    bus.ex_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
